adc_spi_reader: RTL and testbench

SPI master that reads one signed sample from the control loop's ADC per request, driving `sck` and `ss_L` and shifting in `miso` MSB-first. It is the initiator for the ADC-emulating SPI slave used in the control-loop simulation top and for the real ADC on hardware. It sits between the ADC pins and `control_loop`, exposing a level arm/finished handshake and a latched sample word.

---
 rtl/adc_spi_reader_pkg.sv | 31 +++
 rtl/spi_sck_timer.sv | 65 ++++++
 rtl/adc_spi_reader.sv | 157 +++++++++++++++
 tb/tb_adc_spi_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_reader_pkg.sv
// ============================================================================
// Module  : adc_spi_reader_pkg
// Brief   : State encoding and SPI mode constants shared by the ADC reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package adc_spi_reader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_SHIFT = ST_SHIFT,
        S_HOLD  = ST_HOLD,
        S_DONE  = ST_DONE
    } state_t;

    localparam logic CPOL_IDLE_LOW  = 1'b0;
    localparam logic CPOL_IDLE_HIGH = 1'b1;
    localparam logic CPHA_LEADING   = 1'b0;
    localparam logic CPHA_TRAILING  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spi_sck_timer.sv
// ============================================================================
// Module  : spi_sck_timer
// Brief   : SPI half-period timer and sck edge counter with sample-edge select.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_sck_timer #(
    parameter int HALF_WAIT = 5,
    parameter int TIMER_LEN = 3,
    parameter int EDGES     = 36,
    parameter int CNT_LEN   = 6,
    parameter int PHASE     = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic edge_en,
    output logic tick,
    output logic edge_pulse,
    output logic sample_pulse,
    output logic last_edge
);

    localparam logic [TIMER_LEN-1:0] HALF_LAST = TIMER_LEN'(HALF_WAIT - 1);
    localparam logic [CNT_LEN-1:0]   EDGE_LAST = CNT_LEN'(EDGES - 1);
    localparam logic                 PHASE_BIT = 1'(PHASE);

    logic [TIMER_LEN-1:0] timer_q, timer_d;
    logic [CNT_LEN-1:0]   edge_cnt_q, edge_cnt_d;

    assign tick         = run && (timer_q == HALF_LAST);
    assign edge_pulse   = tick && edge_en;
    // Edges are numbered from 1; odd edges lead, so an even count precedes a leading edge.
    assign sample_pulse = edge_pulse && (edge_cnt_q[0] == PHASE_BIT);
    assign last_edge    = edge_pulse && (edge_cnt_q == EDGE_LAST);

    always_comb begin
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        if (clear) begin
            timer_d    = '0;
            edge_cnt_d = '0;
        end else if (run) begin
            timer_d = tick ? '0 : timer_q + TIMER_LEN'(1);
            if (edge_pulse) begin
                edge_cnt_d = edge_cnt_q + CNT_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            edge_cnt_q <= '0;
        end else begin
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_spi_reader.sv
// ============================================================================
// Module  : adc_spi_reader
// Brief   : SPI master reading one signed ADC sample per arm request.
//           Define ADC_SPI_READER_MISO_SYNC_EN to double-flop miso.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_spi_reader
    import adc_spi_reader_pkg::*;
#(
    parameter int WID             = 18,
    parameter int WID_LEN         = 5,
    parameter int POLARITY        = 1,
    parameter int PHASE           = 0,
    parameter int CYCLE_HALF_WAIT = 5,
    parameter int TIMER_LEN       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    output logic                  finished,
    output logic signed [WID-1:0] data_out,
    output logic                  sck,
    output logic                  ss_L,
    input  logic                  miso
);

    localparam logic SCK_IDLE = (POLARITY != 0) ? CPOL_IDLE_HIGH : CPOL_IDLE_LOW;

    state_t         state_q, state_d;
    logic           ss_l_q, ss_l_d;
    logic           sck_q, sck_d;
    logic           finished_q, finished_d;
    logic [WID-1:0] data_out_q, data_out_d;
    logic [WID-1:0] shift_q, shift_d;

    logic tick, edge_pulse, sample_pulse, last_edge;
    logic miso_s, sample_now;

    spi_sck_timer #(
        .HALF_WAIT (CYCLE_HALF_WAIT),
        .TIMER_LEN (TIMER_LEN),
        .EDGES     (2 * WID),
        .CNT_LEN   (WID_LEN + 1),
        .PHASE     (PHASE)
    ) u_sck_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_q == S_IDLE),
        .run          ((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD)),
        .edge_en      ((state_q == S_SETUP) || (state_q == S_SHIFT)),
        .tick         (tick),
        .edge_pulse   (edge_pulse),
        .sample_pulse (sample_pulse),
        .last_edge    (last_edge)
    );

`ifdef ADC_SPI_READER_MISO_SYNC_EN
    // The sample strobe is delayed to match the synchronizer so the same bit is captured.
    logic [1:0] miso_sync_q, miso_sync_d;
    logic [1:0] sample_dly_q, sample_dly_d;

    always_comb begin
        miso_sync_d  = {miso_sync_q[0], miso};
        sample_dly_d = {sample_dly_q[0], sample_pulse};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_sync_q  <= '0;
            sample_dly_q <= '0;
        end else begin
            miso_sync_q  <= miso_sync_d;
            sample_dly_q <= sample_dly_d;
        end
    end

    assign miso_s     = miso_sync_q[1];
    assign sample_now = sample_dly_q[1];
`else
    assign miso_s     = miso;
    assign sample_now = sample_pulse;
`endif

    always_comb begin
        state_d    = state_q;
        ss_l_d     = ss_l_q;
        sck_d      = sck_q;
        finished_d = finished_q;
        data_out_d = data_out_q;
        shift_d    = shift_q;

        if (sample_now) begin
            shift_d = {shift_q[WID-2:0], miso_s};
        end

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    ss_l_d  = 1'b0;
                    state_d = S_SETUP;
                end
            end
            // The setup half-period ends on the first sck edge.
            S_SETUP, S_SHIFT: begin
                if (edge_pulse) begin
                    sck_d   = ~sck_q;
                    state_d = last_edge ? S_HOLD : S_SHIFT;
                end
            end
            S_HOLD: begin
                if (tick) begin
                    ss_l_d     = 1'b1;
                    data_out_d = shift_q;
                    finished_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (!arm) begin
                    finished_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ss_l_q     <= 1'b1;
            sck_q      <= SCK_IDLE;
            finished_q <= 1'b0;
            data_out_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            ss_l_q     <= ss_l_d;
            sck_q      <= sck_d;
            finished_q <= finished_d;
            data_out_q <= data_out_d;
            shift_q    <= shift_d;
        end
    end

    assign finished = finished_q;
    assign data_out = data_out_q;
    assign sck      = sck_q;
    assign ss_L     = ss_l_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
// ============================================================================
// Module  : tb_adc_spi_reader
// Brief   : Scoreboard bench for adc_spi_reader with mode-0/CPOL=1 and mode CPHA=1/CPOL=0 slaves.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_spi_reader;

    localparam int WID  = 18;
    localparam int HALF = 5;
    localparam int LAT  = 1 + (2 * WID + 1) * HALF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] arm = 2'b00;
    logic [1:0] finished, sck, ss_L, miso;
    logic [WID-1:0] data_out [2];
    logic [WID-1:0] slave_word [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [WID-1:0] word;
        int             sval;
        int             t0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int edges [2];
    int ss_fall_cyc [2];
    int first_edge_cyc [2];
    logic [1:0] ss_prev  = 2'b11;
    logic [1:0] sck_prev = 2'b01;
    logic [1:0] fin_prev = 2'b00;

    adc_spi_reader dut0 (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm[0]),
        .finished (finished[0]),
        .data_out (data_out[0]),
        .sck      (sck[0]),
        .ss_L     (ss_L[0]),
        .miso     (miso[0])
    );

    adc_spi_reader #(
        .WID(18), .WID_LEN(5), .POLARITY(0), .PHASE(1), .CYCLE_HALF_WAIT(5), .TIMER_LEN(3)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm[1]),
        .finished (finished[1]),
        .data_out (data_out[1]),
        .sck      (sck[1]),
        .ss_L     (ss_L[1]),
        .miso     (miso[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ADC slaves: CPHA=0 presents the MSB at select and shifts on trailing
    // edges; CPHA=1 presents each bit on the leading edge.
    for (genvar g = 0; g < 2; g++) begin : g_slave
        localparam logic CPOL = (g == 0);
        localparam logic CPHA = (g != 0);
        logic so = 1'b0;
        logic ss_seen = 1'b1;
        int   idx = 0;

        always @(sck[g] or ss_L[g]) begin
            if (ss_seen && ss_L[g] == 1'b0) begin
                idx = WID - 1;
                if (!CPHA) so = slave_word[g][idx];
            end else if (ss_L[g] == 1'b0) begin
                if (sck[g] != CPOL) begin
                    if (CPHA && idx >= 0) begin
                        so = slave_word[g][idx];
                        idx--;
                    end
                end else if (!CPHA) begin
                    idx--;
                    if (idx >= 0) so = slave_word[g][idx];
                end
            end
            ss_seen = (ss_L[g] !== 1'b0);
        end

        assign miso[g] = so;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: edge bookkeeping plus scoreboard pop on every finished rise.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ss_prev[g] && !ss_L[g]) begin
                edges[g]       = 0;
                ss_fall_cyc[g] = cyc;
            end else if (!ss_L[g] && sck[g] != sck_prev[g]) begin
                edges[g]++;
                if (edges[g] == 1) first_edge_cyc[g] = cyc;
            end

            if (finished[g] && !fin_prev[g]) begin
                if (((g == 0) ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("unexpected_finish_%0d", g), 1, 0);
                end else begin
                    exp_t e;
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("data_%0d", g), data_out[g], e.word);
                    check($sformatf("data_signed_%0d", g), $signed(data_out[g]), e.sval);
                    check($sformatf("finish_cycle_%0d", g), cyc, e.t0 + LAT);
                    check($sformatf("ss_fall_cycle_%0d", g), ss_fall_cyc[g], e.t0 + 1);
                    check($sformatf("first_edge_cycle_%0d", g), first_edge_cyc[g], e.t0 + 1 + HALF);
                    check($sformatf("edge_count_%0d", g), edges[g], 2 * WID);
                    check($sformatf("ss_idle_%0d", g), ss_L[g], 1);
                    check($sformatf("sck_idle_%0d", g), sck[g], (g == 0) ? 1 : 0);
                end
            end
        end
        ss_prev  = ss_L;
        sck_prev = sck;
        fin_prev = finished;
    end

    task automatic start_read(input int g, input logic [WID-1:0] w, input int sval);
        exp_t e;
        @(negedge clk);
        slave_word[g] = w;
        arm[g] = 1'b1;
        e.word = w;
        e.sval = sval;
        e.t0   = cyc;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_finished(input int g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (finished[g]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("finish_timeout_%0d", g), 0, 1);
    endtask

    initial begin
        int bad;
        slave_word[0] = '0;
        slave_word[1] = '0;

        repeat (2) @(negedge clk);
        check("rst_ss_L_0", ss_L[0], 1);
        check("rst_ss_L_1", ss_L[1], 1);
        check("rst_sck_0", sck[0], 1);
        check("rst_sck_1", sck[1], 0);
        check("rst_finished_0", finished[0], 0);
        check("rst_data_0", data_out[0], 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain read, then arm held high after completion.
        start_read(0, 18'h2A5C3, -88637);
        wait_finished(0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (finished[0] !== 1'b1 || ss_L[0] !== 1'b1) bad++;
        end
        check("hold_high_bad_cycles", bad, 0);
        arm[0] = 1'b0;
        @(negedge clk);
        check("finished_fall", finished[0], 0);

        // Most negative sample; data_out must hold the previous word meanwhile.
        start_read(0, 18'h20000, -131072);
        repeat (100) @(negedge clk);
        check("data_hold_mid_transfer", data_out[0], 18'h2A5C3);
        wait_finished(0);
        arm[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Most positive sample with arm dropped mid-transfer: one-cycle finished.
        start_read(0, 18'h1FFFF, 131071);
        repeat (20) @(negedge clk);
        arm[0] = 1'b0;
        wait_finished(0);
        @(negedge clk);
        check("finished_one_cycle", finished[0], 0);
        repeat (3) @(negedge clk);

        // CPHA=1, CPOL=0 instance.
        start_read(1, 18'h15555, 87381);
        wait_finished(1);
        arm[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of SHIFT; no expectation is queued for this transfer.
        @(negedge clk);
        slave_word[0] = 18'h3FFFF;
        arm[0] = 1'b1;
        bad = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ss_L[0] && edges[0] == 10) begin
                bad = 0;
                break;
            end
        end
        check("reach_edge_10", bad, 0);
        rst = 1'b1;
        #1;
        check("midrst_ss_L", ss_L[0], 1);
        check("midrst_sck", sck[0], 1);
        check("midrst_finished", finished[0], 0);
        check("midrst_data", data_out[0], 0);
        arm[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_data", data_out[0], 0);

        start_read(0, 18'h0F0F0, 61680);
        wait_finished(0);
        arm[0] = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
